// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    CMP,
    DONE
  } state_e;

  localparam int unsigned MAX_READ_LATENCY = 3;
  localparam int unsigned LAT_W            = $clog2(MAX_READ_LATENCY + 1);

  localparam logic WORD_ID = 1'b0;
  localparam logic WORD_TS = 1'b1;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the system-ID slave.
interface sysid_checker_if;
  logic        sysid_address;
  logic        sysid_read;
  logic [31:0] sysid_readdata;

  modport master (output sysid_address, output sysid_read, input  sysid_readdata);
  modport slave  (input  sysid_address, input  sysid_read, output sysid_readdata);
endinterface

// File: rtl/sysid_checker.sv
// Reads system-ID words 0/1, compares against build-time values, latches pass/fail.
// Optional periodic re-check enabled by defining SYSID_CHECK_PERIODIC_EN.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID   = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS   = 32'd1740515352,
  parameter int unsigned READ_LATENCY  = 0,
  parameter bit          AUTO_START    = 1'b1,
  parameter int unsigned PERIOD_CYCLES = 50_000_000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  sysid_checker_if.master        sysid,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   id_ok,
  output logic                   ts_ok,
  output logic                   mismatch,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value
);

  if (READ_LATENCY > MAX_READ_LATENCY || PERIOD_CYCLES == 0) begin : g_param_check
    $error("sysid_checker: READ_LATENCY must be 0..%0d and PERIOD_CYCLES nonzero",
           MAX_READ_LATENCY);
  end

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               pend_q, pend_d;
  logic [31:0]        cap_id_q, cap_id_d;
  logic [31:0]        cap_ts_q, cap_ts_d;
  logic               id_ok_q, id_ok_d;
  logic               ts_ok_q, ts_ok_d;
  logic               mis_q, mis_d;
  logic [31:0]        id_val_q, id_val_d;
  logic [31:0]        ts_val_q, ts_val_d;
  logic               rd;
  logic               addr;
  logic               trig;

`ifdef SYSID_CHECK_PERIODIC_EN
  localparam int unsigned PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  logic [PER_W-1:0] per_cnt_q;

  assign trig = (per_cnt_q == PER_W'(PERIOD_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt_q <= '0;
    end else if (trig) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_q + 1'b1;
    end
  end
`else
  assign trig = 1'b0;
`endif

  // Words land in capture registers and are only published in CMP, so the
  // reported values never show a half-finished check.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    pend_d   = pend_q | trig;
    cap_id_d = cap_id_q;
    cap_ts_d = cap_ts_q;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    mis_d    = mis_q;
    id_val_d = id_val_q;
    ts_val_d = ts_val_q;
    rd       = 1'b0;
    addr     = WORD_ID;

    case (state_q)
      IDLE: begin
        if (start || pend_q) begin
          state_d = RD_ID;
          pend_d  = trig;
        end
      end
      RD_ID: begin
        rd = 1'b1;
        if (READ_LATENCY == 0) begin
          cap_id_d = sysid.sysid_readdata;
          state_d  = RD_TS;
        end else begin
          lat_d   = LAT_W'(READ_LATENCY - 1);
          state_d = WAIT_ID;
        end
      end
      WAIT_ID: begin
        if (lat_q == '0) begin
          cap_id_d = sysid.sysid_readdata;
          state_d  = RD_TS;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RD_TS: begin
        rd   = 1'b1;
        addr = WORD_TS;
        if (READ_LATENCY == 0) begin
          cap_ts_d = sysid.sysid_readdata;
          state_d  = CMP;
        end else begin
          lat_d   = LAT_W'(READ_LATENCY - 1);
          state_d = WAIT_TS;
        end
      end
      WAIT_TS: begin
        addr = WORD_TS;
        if (lat_q == '0) begin
          cap_ts_d = sysid.sysid_readdata;
          state_d  = CMP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      CMP: begin
        id_ok_d  = (cap_id_q == EXPECTED_ID);
        ts_ok_d  = (cap_ts_q == EXPECTED_TS);
        mis_d    = mis_q | (cap_id_q != EXPECTED_ID) | (cap_ts_q != EXPECTED_TS);
        id_val_d = cap_id_q;
        ts_val_d = cap_ts_q;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      pend_q   <= AUTO_START;
      cap_id_q <= '0;
      cap_ts_q <= '0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      mis_q    <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      pend_q   <= pend_d;
      cap_id_q <= cap_id_d;
      cap_ts_q <= cap_ts_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      mis_q    <= mis_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end

  assign sysid.sysid_read    = rd;
  assign sysid.sysid_address = addr;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign mismatch = mis_q;
  assign id_value = id_val_q;
  assign ts_value = ts_val_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: one instance at READ_LATENCY=0, one at READ_LATENCY=2.
module tb_sysid_checker;
  import sysid_checker_pkg::*;

  typedef struct packed {
    logic        id_ok;
    logic        ts_ok;
    logic        mis;
    logic [31:0] idv;
    logic [31:0] tsv;
  } res_t;

  localparam logic [31:0] TS_GOOD = 32'd1740515352;
  localparam logic [31:0] ID2     = 32'hCAFE_0001;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start0  = 1'b0;
  logic        start2  = 1'b0;
  logic [31:0] s0_id = '0, s0_ts = '0, s2_id = '0, s2_ts = '0;
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  res_t        exp0_q[$];
  res_t        exp2_q[$];

  logic        busy0, done0, idok0, tsok0, mis0;
  logic        busy2, done2, idok2, tsok2, mis2;
  logic [31:0] idv0, tsv0, idv2, tsv2;

  sysid_checker_if if0 ();
  sysid_checker_if if2 ();

  sysid_checker #(
    .EXPECTED_ID  (32'h0000_0000),
    .EXPECTED_TS  (TS_GOOD),
    .READ_LATENCY (0),
    .AUTO_START   (1'b1),
    .PERIOD_CYCLES(100)
  ) u_dut0 (
    .clock(clock), .reset_n(reset_n), .sysid(if0), .start(start0),
    .busy(busy0), .done(done0), .id_ok(idok0), .ts_ok(tsok0), .mismatch(mis0),
    .id_value(idv0), .ts_value(tsv0)
  );

  sysid_checker #(
    .EXPECTED_ID  (ID2),
    .EXPECTED_TS  (TS_GOOD),
    .READ_LATENCY (2),
    .AUTO_START   (1'b1),
    .PERIOD_CYCLES(100)
  ) u_dut2 (
    .clock(clock), .reset_n(reset_n), .sysid(if2), .start(start2),
    .busy(busy2), .done(done2), .id_ok(idok2), .ts_ok(tsok2), .mismatch(mis2),
    .id_value(idv2), .ts_value(tsv2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave models: zero-latency combinational, and a two-stage pipelined one
  // that drives garbage whenever data is not valid.
  assign if0.sysid_readdata = if0.sysid_read ? (if0.sysid_address ? s0_ts : s0_id) : 32'hDEAD_BEEF;

  logic p1_v, p1_a, p2_v, p2_a;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1_v <= 1'b0; p1_a <= 1'b0; p2_v <= 1'b0; p2_a <= 1'b0;
    end else begin
      p1_v <= if2.sysid_read; p1_a <= if2.sysid_address;
      p2_v <= p1_v;           p2_a <= p1_a;
    end
  end
  assign if2.sysid_readdata = p2_v ? (p2_a ? s2_ts : s2_id) : 32'hDEAD_BEEF;

  // Scoreboard: each done pulse consumes the oldest expected result.
  always @(negedge clock) begin
    res_t e, g;
    if (done0) begin
      g = {idok0, tsok0, mis0, idv0, tsv0};
      total++;
      if (exp0_q.size() == 0) begin
        bad++;
        $display("FAIL sb0_unexpected_done: got %h, nothing expected (cyc %0d)", g, cyc);
      end else begin
        e = exp0_q.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL sb0_result: got %h, want %h (cyc %0d)", g, e, cyc);
        end
      end
    end
    if (done2) begin
      g = {idok2, tsok2, mis2, idv2, tsv2};
      total++;
      if (exp2_q.size() == 0) begin
        bad++;
        $display("FAIL sb2_unexpected_done: got %h, nothing expected (cyc %0d)", g, cyc);
      end else begin
        e = exp2_q.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL sb2_result: got %h, want %h (cyc %0d)", g, e, cyc);
        end
      end
    end
  end

  int rid[2], rts[2], dn[2], ndone[2], rid_nx[2];
  bit busy_drop[2];

  task automatic observe(input int ncyc, input int base, input bit keep0);
    logic rd[2], ad[2], ds[2], bz[2];
    for (int i = 0; i < 2; i++) begin
      rid[i] = -1; rts[i] = -1; dn[i] = -1; ndone[i] = 0; rid_nx[i] = -1; busy_drop[i] = 1'b0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      rd[0] = if0.sysid_read; ad[0] = if0.sysid_address; ds[0] = done0; bz[0] = busy0;
      rd[1] = if2.sysid_read; ad[1] = if2.sysid_address; ds[1] = done2; bz[1] = busy2;
      for (int i = 0; i < 2; i++) begin
        if (rd[i] && !ad[i]) begin
          if (rid[i] < 0) rid[i] = cyc - base;
          else if (dn[i] >= 0 && rid_nx[i] < 0) rid_nx[i] = cyc - base;
        end
        if (rd[i] && ad[i] && rts[i] < 0) rts[i] = cyc - base;
        if (rid[i] >= 0 && dn[i] < 0 && !bz[i]) busy_drop[i] = 1'b1;
        if (ds[i]) begin
          ndone[i]++;
          if (dn[i] < 0) dn[i] = cyc - base;
        end
      end
      if (!keep0) start0 = 1'b0;
      start2 = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if ({busy0, done0, idok0, tsok0, mis0, idv0, tsv0, if0.sysid_read, if0.sysid_address} !== '0) begin
      bad++;
      $display("FAIL reset0: got busy=%b done=%b ok=%b%b mis=%b id=%h ts=%h rd=%b ad=%b, want all 0",
               busy0, done0, idok0, tsok0, mis0, idv0, tsv0, if0.sysid_read, if0.sysid_address);
    end
    total++;
    if ({busy2, done2, idok2, tsok2, mis2, idv2, tsv2, if2.sysid_read, if2.sysid_address} !== '0) begin
      bad++;
      $display("FAIL reset2: got busy=%b done=%b ok=%b%b mis=%b id=%h ts=%h rd=%b ad=%b, want all 0",
               busy2, done2, idok2, tsok2, mis2, idv2, tsv2, if2.sysid_read, if2.sysid_address);
    end
  endtask

  task automatic test_auto();
    int base;
    s0_id = 32'h0; s0_ts = TS_GOOD; s2_id = ID2; s2_ts = TS_GOOD;
    exp0_q.push_back('{1'b1, 1'b1, 1'b0, 32'h0, TS_GOOD});
    exp2_q.push_back('{1'b1, 1'b1, 1'b0, ID2, TS_GOOD});
    @(negedge clock);
    reset_n = 1'b1;
    base = cyc;
    observe(12, base, 1'b0);
    total++;
    if (rid[0] != 1 || rts[0] != 2 || dn[0] != 4 || ndone[0] != 1 || busy_drop[0]) begin
      bad++;
      $display("FAIL auto0_timing: got rid=%0d rts=%0d done=%0d n=%0d busydrop=%b, want 1 2 4 1 0",
               rid[0], rts[0], dn[0], ndone[0], busy_drop[0]);
    end
    total++;
    if (rid[1] != 1 || rts[1] != 4 || dn[1] != 8 || ndone[1] != 1 || busy_drop[1]) begin
      bad++;
      $display("FAIL auto2_timing: got rid=%0d rts=%0d done=%0d n=%0d busydrop=%b, want 1 4 8 1 0",
               rid[1], rts[1], dn[1], ndone[1], busy_drop[1]);
    end
  endtask

  task automatic test_mismatch();
    logic [31:0] ids[3]  = '{32'h0, 32'h0, 32'h0000_0001};
    logic [31:0] tss[3]  = '{32'h1234_5678, TS_GOOD, TS_GOOD};
    logic        idok[3] = '{1'b1, 1'b1, 1'b0};
    logic        tsok[3] = '{1'b0, 1'b1, 1'b1};
    int base;
    for (int t = 0; t < 3; t++) begin
      s0_id = ids[t]; s0_ts = tss[t];
      exp0_q.push_back('{idok[t], tsok[t], 1'b1, ids[t], tss[t]});
      start0 = 1'b1;
      base = cyc;
      observe(8, base, 1'b0);
      total++;
      if (dn[0] != 4 || ndone[0] != 1) begin
        bad++;
        $display("FAIL mismatch_done_%0d: got done=%0d n=%0d, want 4 1", t, dn[0], ndone[0]);
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] ids[2] = '{ID2, 32'h0BAD_F00D};
    int base;
    for (int t = 0; t < 2; t++) begin
      s2_id = ids[t]; s2_ts = TS_GOOD;
      exp2_q.push_back('{(ids[t] == ID2), 1'b1, (t == 1), ids[t], TS_GOOD});
      start2 = 1'b1;
      base = cyc;
      observe(12, base, 1'b0);
      total++;
      if (rid[1] != 1 || rts[1] != 4 || dn[1] != 8 || ndone[1] != 1) begin
        bad++;
        $display("FAIL latency_timing_%0d: got rid=%0d rts=%0d done=%0d n=%0d, want 1 4 8 1",
                 t, rid[1], rts[1], dn[1], ndone[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    s0_id = 32'h0; s0_ts = TS_GOOD;
    exp0_q.push_back('{1'b1, 1'b1, 1'b1, 32'h0, TS_GOOD});
    exp0_q.push_back('{1'b1, 1'b1, 1'b1, 32'h0, TS_GOOD});
    start0 = 1'b1;
    base = cyc;
    observe(10, base, 1'b1);
    start0 = 1'b0;
    total++;
    if (rid[0] != 1 || dn[0] != 4 || rid_nx[0] != 6 || ndone[0] != 2 || busy_drop[0]) begin
      bad++;
      $display("FAIL back_to_back: got rid=%0d done=%0d next_rid=%0d n=%0d busydrop=%b, want 1 4 6 2 0",
               rid[0], dn[0], rid_nx[0], ndone[0], busy_drop[0]);
    end
    repeat (6) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int base;
    s2_id = ID2; s2_ts = TS_GOOD;
    start2 = 1'b1;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clock);
      start2 = 1'b0;
      if (if2.sysid_read && if2.sysid_address) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_mid_rdts: got no RD_TS within 10 cycles, want one");
    end
    @(posedge clock);
    #2;
    total++;
    if ({busy2, if2.sysid_address, if2.sysid_read} !== 3'b110) begin
      bad++;
      $display("FAIL reset_mid_waitts: got busy=%b ad=%b rd=%b, want 1 1 0",
               busy2, if2.sysid_address, if2.sysid_read);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({busy0, done0, idok0, tsok0, mis0, idv0, tsv0, if0.sysid_read, if0.sysid_address,
         busy2, done2, idok2, tsok2, mis2, idv2, tsv2, if2.sysid_read, if2.sysid_address} !== '0) begin
      bad++;
      $display("FAIL reset_mid_clear: got busy=%b%b ok0=%b%b ok2=%b%b mis=%b%b id2=%h ts2=%h rd2=%b ad2=%b, want all 0",
               busy0, busy2, idok0, tsok0, idok2, tsok2, mis0, mis2, idv2, tsv2,
               if2.sysid_read, if2.sysid_address);
    end
    exp0_q.push_back('{1'b1, 1'b1, 1'b0, 32'h0, TS_GOOD});
    exp2_q.push_back('{1'b1, 1'b1, 1'b0, ID2, TS_GOOD});
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    base = cyc;
    observe(12, base, 1'b0);
    total++;
    if (rid[1] != 1 || rts[1] != 4 || dn[1] != 8 || ndone[1] != 1) begin
      bad++;
      $display("FAIL reset_mid_restart: got rid=%0d rts=%0d done=%0d n=%0d, want 1 4 8 1",
               rid[1], rts[1], dn[1], ndone[1]);
    end
  endtask

  task automatic test_periodic();
    int base, c;
    int d0[$];
    int d2[$];
    int w0[5] = '{4, 100, 105, 204, 304};
    int w2[4] = '{8, 108, 208, 308};
    bit ok0, ok2;
    s0_id = 32'h0; s0_ts = TS_GOOD; s2_id = ID2; s2_ts = TS_GOOD;
    repeat (5) exp0_q.push_back('{1'b1, 1'b1, 1'b0, 32'h0, TS_GOOD});
    repeat (4) exp2_q.push_back('{1'b1, 1'b1, 1'b0, ID2, TS_GOOD});
    @(negedge clock);
    reset_n = 1'b1;
    base = cyc;
    for (int n = 0; n < 320; n++) begin
      @(negedge clock);
      c = cyc - base;
      if (done0) d0.push_back(c);
      if (done2) d2.push_back(c);
      start0 = (c == 96);
    end
    ok0 = (d0.size() == 5);
    for (int i = 0; i < 5 && ok0; i++) if (d0[i] != w0[i]) ok0 = 1'b0;
    ok2 = (d2.size() == 4);
    for (int i = 0; i < 4 && ok2; i++) if (d2[i] != w2[i]) ok2 = 1'b0;
    total++;
    if (!ok0) begin
      bad++;
      $display("FAIL periodic0: got %0d dones %p, want 4 100 105 204 304", d0.size(), d0);
    end
    total++;
    if (!ok2) begin
      bad++;
      $display("FAIL periodic2: got %0d dones %p, want 8 108 208 308", d2.size(), d2);
    end
  endtask

  initial begin
`ifdef SYSID_CHECK_PERIODIC_EN
    test_reset();
    test_periodic();
`else
    test_reset();
    test_auto();
    test_mismatch();
    test_latency();
    test_back_to_back();
    test_reset_mid();
`endif
    repeat (4) @(negedge clock);
    total++;
    if (exp0_q.size() != 0) begin
      bad++;
      $display("FAIL sb0_leftover: got %0d unmatched expectations, want 0", exp0_q.size());
    end
    total++;
    if (exp2_q.size() != 0) begin
      bad++;
      $display("FAIL sb2_leftover: got %0d unmatched expectations, want 0", exp2_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
